stream_demultiplexer: RTL and testbench

Registered, packet-aware demultiplexer for the communications processor datapath. It is the fan-out counterpart of the combinational `multiplexer`. It accepts one valid/ready input stream and steers each packet to one of 2**NUM_OF_CONTROL_SIGNALS output channels. The destination is chosen by a select value sampled on the packet's first beat. Each output channel has a one-entry register slice, so a stalled channel never blocks delivery already queued on other channels.

---
 rtl/stream_demultiplexer.sv | 141 ++++++++++++++
 tb/tb_stream_demultiplexer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_demultiplexer.sv
// Registered packet-aware demux: each packet is steered to one of 2**NUM_OF_CONTROL_SIGNALS
// one-entry output slots. Define STREAM_DEMUX_PKT_COUNT_EN for per-channel delivered-packet counters.

module stream_demux_slot #(
  parameter int WIDTH       = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
`ifdef STREAM_DEMUX_PKT_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] count_o
`endif
);
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             last_q;

  // A load wins over a drain, so a simultaneous pop+push keeps the slot full.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

`ifdef STREAM_DEMUX_PKT_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset)                           count_q <= '0;
    else if (valid_q && ready_i && last_q) count_q <= count_q + 1'b1;
  end

  assign count_o = count_q;
`endif
endmodule

module stream_demultiplexer #(
  parameter  int NUM_OF_CONTROL_SIGNALS = 1,
  parameter  int WIDTH                  = 1,
  parameter  int COUNT_WIDTH            = 16,
  localparam int N                      = 2 ** NUM_OF_CONTROL_SIGNALS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic                              in_last,
  input  logic [NUM_OF_CONTROL_SIGNALS-1:0] in_select,
  output logic [N-1:0]                      out_valid,
  input  logic [N-1:0]                      out_ready,
  output logic [WIDTH-1:0]                  out_data [N],
  output logic [N-1:0]                      out_last,
  output logic                              busy,
  output logic [NUM_OF_CONTROL_SIGNALS-1:0] current_select
`ifdef STREAM_DEMUX_PKT_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0]            packet_count [N]
`endif
);
  typedef enum logic {IDLE, ROUTE} state_t;

  state_t                            state_q, state_d;
  logic [NUM_OF_CONTROL_SIGNALS-1:0] sel_q, sel_d;
  logic [NUM_OF_CONTROL_SIGNALS-1:0] tgt;
  logic                              xfer;

  // Route is only sampled on a packet's first beat; afterwards it is locked.
  assign tgt      = (state_q == ROUTE) ? sel_q : in_select;
  assign in_ready = !out_valid[tgt] || out_ready[tgt];
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (xfer) begin
      case (state_q)
        IDLE: begin
          sel_d = in_select;
          if (!in_last) state_d = ROUTE;
        end
        ROUTE: if (in_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy           = (state_q == ROUTE);
  assign current_select = sel_q;

  for (genvar k = 0; k < N; k++) begin : g_slot
    stream_demux_slot #(
      .WIDTH       (WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load_i  (xfer && (tgt == NUM_OF_CONTROL_SIGNALS'(k))),
      .data_i  (in_data),
      .last_i  (in_last),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k]),
      .last_o  (out_last[k])
`ifdef STREAM_DEMUX_PKT_COUNT_EN
      ,
      .count_o (packet_count[k])
`endif
    );
  end
endmodule

// File: tb/tb_stream_demultiplexer.sv
// Bench for stream_demultiplexer (4 channels, 8-bit beats): directed vector table,
// reset/counter sequences, then random traffic against a per-channel queue model.

module tb_stream_demultiplexer;
  localparam int NCS = 2;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready, in_last, busy;
  logic [W-1:0]   in_data;
  logic [NCS-1:0] in_select, current_select;
  logic [N-1:0]   out_valid, out_ready, out_last;
  logic [W-1:0]   out_data [N];
`ifdef STREAM_DEMUX_PKT_COUNT_EN
  logic [CW-1:0]  packet_count [N];
`endif

  stream_demultiplexer #(
    .NUM_OF_CONTROL_SIGNALS (NCS),
    .WIDTH                  (W),
    .COUNT_WIDTH            (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_select      (in_select),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .current_select (current_select)
`ifdef STREAM_DEMUX_PKT_COUNT_EN
    ,
    .packet_count   (packet_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs applied at a falling edge; expectations describe outputs at that same falling edge.
  typedef struct {
    logic           v;
    logic [NCS-1:0] sel;
    logic [W-1:0]   d;
    logic           l;
    logic [N-1:0]   ordy;
    logic [N-1:0]   e_ov;
    logic           e_ir;
    logic           e_busy;
    logic [NCS-1:0] e_cs;
    int             ch;
    logic [W-1:0]   e_d;
    logic           e_l;
  } vec_t;

  vec_t vecs [13];

  // Reference model: one queue of pending beats {last,data} per channel, plus packet route.
  logic [W:0] mq [N][$];
  bit         m_inpkt;
  int         m_route;
  int         m_cnt [N];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_select = '0;
    out_ready = '1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin mq[k].delete(); m_cnt[k] = 0; end
    m_inpkt = 0; m_route = 0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 2'd0,  0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 8'hA5, 1'b1, 4'hF, 4'b0000, 1'b1, 1'b0, 2'd0,  0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 2'd1, 8'h11, 1'b0, 4'hF, 4'b0100, 1'b1, 1'b0, 2'd2,  2, 8'hA5, 1'b1};
    vecs[3]  = '{1'b1, 2'd3, 8'h22, 1'b0, 4'hF, 4'b0010, 1'b1, 1'b1, 2'd1,  1, 8'h11, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 8'h33, 1'b1, 4'hF, 4'b0010, 1'b1, 1'b1, 2'd1,  1, 8'h22, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 4'b0010, 1'b1, 1'b0, 2'd1,  1, 8'h33, 1'b1};
    vecs[6]  = '{1'b1, 2'd0, 8'h44, 1'b1, 4'hE, 4'b0000, 1'b1, 1'b0, 2'd1, -1, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 2'd0, 8'h55, 1'b1, 4'hE, 4'b0001, 1'b0, 1'b0, 2'd0,  0, 8'h44, 1'b1};
    vecs[8]  = '{1'b1, 2'd3, 8'h66, 1'b1, 4'hE, 4'b0001, 1'b1, 1'b0, 2'd0,  0, 8'h44, 1'b1};
    vecs[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hE, 4'b1001, 1'b0, 1'b0, 2'd3,  3, 8'h66, 1'b1};
    vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hE, 4'b0001, 1'b0, 1'b0, 2'd3,  0, 8'h44, 1'b1};
    vecs[11] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 4'b0001, 1'b1, 1'b0, 2'd3,  0, 8'h44, 1'b1};
    vecs[12] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 2'd3, -1, 8'h00, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_select = '0; out_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: single beat, 3-beat packet with changing select, stall on channel 0.
    for (int i = 0; i < 13; i++) begin
      in_valid = vecs[i].v; in_select = vecs[i].sel; in_data = vecs[i].d;
      in_last = vecs[i].l; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d current_select", i), 32'(current_select), 32'(vecs[i].e_cs));
      if (vecs[i].ch >= 0) begin
        chk($sformatf("vec%0d out_data[%0d]", i, vecs[i].ch), 32'(out_data[vecs[i].ch]), 32'(vecs[i].e_d));
        chk($sformatf("vec%0d out_last[%0d]", i, vecs[i].ch), 32'(out_last[vecs[i].ch]), 32'(vecs[i].e_l));
      end
      @(negedge clk);
    end

    // Reset pulsed after beat 2 of a 4-beat packet to channel 2.
    in_valid = 1'b1; in_select = 2'd2; in_data = 8'h01; in_last = 1'b0; out_ready = '1;
    @(negedge clk);
    in_select = 2'd0; in_data = 8'h02;
    @(negedge clk);
    chk("rst_mid busy before", 32'(busy), 32'd1);
    chk("rst_mid out_valid before", 32'(out_valid), 32'b0100);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_select = 2'd3;
    #1;
    chk("rst_mid out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid current_select", 32'(current_select), 32'd0);
    chk("rst_mid in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'h99; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rst_mid next out_valid", 32'(out_valid), 32'b1000);
    chk("rst_mid next out_data[3]", 32'(out_data[3]), 32'h99);
    chk("rst_mid next current_select", 32'(current_select), 32'd3);

`ifdef STREAM_DEMUX_PKT_COUNT_EN
    // Five packets to channel 1 wrap a 2-bit counter to 1.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_select = 2'd1; in_data = 8'(i); in_last = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++)
      chk($sformatf("pkt_count[%0d] wrap", k), 32'(packet_count[k]), (k == 1) ? 32'd1 : 32'd0);
`endif

    // Random traffic against the queue model.
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int t;
      bit x;
      in_valid  = ($urandom_range(3) != 0);
      in_select = NCS'($urandom_range(N - 1));
      in_data   = W'($urandom);
      in_last   = ($urandom_range(2) == 0);
      for (int k = 0; k < N; k++) out_ready[k] = ($urandom_range(9) < 7);
      #1;
      t = m_inpkt ? m_route : int'(in_select);
      chk("rnd in_ready", 32'(in_ready), 32'(mq[t].size() == 0 || out_ready[t]));
      chk("rnd busy", 32'(busy), 32'(m_inpkt));
      chk("rnd current_select", 32'(current_select), 32'(m_route));
      for (int k = 0; k < N; k++) begin
        chk($sformatf("rnd out_valid[%0d]", k), 32'(out_valid[k]), 32'(mq[k].size() != 0));
        if (mq[k].size() != 0 && out_valid[k])
          chk($sformatf("rnd beat ch%0d", k), {23'd0, out_last[k], out_data[k]}, 32'(mq[k][0]));
      end
      x = in_valid && (mq[t].size() == 0 || out_ready[t]);
      @(posedge clk);
      for (int k = 0; k < N; k++)
        if (mq[k].size() != 0 && out_ready[k]) begin
          if (mq[k][0][W]) m_cnt[k] = (m_cnt[k] + 1) % (1 << CW);
          void'(mq[k].pop_front());
        end
      if (x) begin
        mq[t].push_back({in_last, in_data});
        if (!m_inpkt) m_route = int'(in_select);
        m_inpkt = !in_last;
      end
      @(negedge clk);
    end
`ifdef STREAM_DEMUX_PKT_COUNT_EN
    for (int k = 0; k < N; k++)
      chk($sformatf("rnd pkt_count[%0d]", k), 32'(packet_count[k]), 32'(m_cnt[k]));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
